dac_setpoint_ramp: RTL
======================

Name: dac_setpoint_ramp

Overview:
Upstream stage of the 4-channel DAC8564 serial driver. Holds a host-written target and slew step per channel. On a fixed update tick, it moves each channel's live setpoint toward its target by at most one step. It then presents the 64-bit Current bus and a Sync pulse; the driver launches its frame on the falling edge of Sync.

Parameters:
UPDATE_DIV, 1000, Clk cycles per update tick; must be >= 256 so a full 4-channel driver frame (~210 cycles) completes between ticks.
SYNC_WIDTH, 4, Clk cycles Sync is held high per update; must be >= 1.

Ports:
Clk  in  1  system clock, max 50 MHz.
nReset  in  1  asynchronous reset, active-low.
WrEn  in  1  host write strobe, single cycle, always accepted.
WrAddr  in  3  bit 2 = 0 selects target, 1 selects step; bits 1:0 select channel 0-3.
WrData  in  16  target (two's complement) or step (unsigned).
Enable  in  1  1 = tick-driven updates run; 0 = outputs frozen.
Current  out  64  live setpoints; Current[16k+15:16k] is channel k, two's complement; [63:48] drives DAC output A, [15:0] drives output D.
Sync  out  1  update strobe; falling edge is the driver trigger.
Settled  out  4  bit k = 1 when channel k live value equals its target.

Behaviour:
- Reset: Current=0, all targets=0, all steps=0, Sync=0, Settled=4'hF, tick counter=0, FSM=IDLE. Reset mid-sequence aborts the sequence immediately; no Sync edge is produced.
- Tick counter: free-runs 0..UPDATE_DIV-1 regardless of Enable, then wraps to 0. The tick asserts in the cycle where count==UPDATE_DIV-1.
- FSM states: IDLE, CALC (channel index 0..3), SYNC_HI (SYNC_WIDTH-cycle counter).
- IDLE -> CALC ch0 when tick & Enable. Otherwise IDLE holds.
- CALC: processes one channel per cycle, ch0 first. ch3 -> SYNC_HI.
- SYNC_HI: Sync=1 for exactly SYNC_WIDTH cycles, then Sync=0 and -> IDLE.
- Timing for a tick at cycle T: Current field k updates at the edge ending cycle T+1+k. Sync is high T+5 .. T+4+SYNC_WIDTH, low thereafter.
- Sync is emitted on every enabled tick, even if no channel changed. The driver discards unchanged frames.
- Step arithmetic per channel, 17-bit signed: diff = target - live.
  - If step==0 or |diff| <= step: live <= target.
  - Else if diff > 0: live <= live + step.
  - Else: live <= live - step.
  - The result always lies between live and target, so no overflow or wrap is possible.
- Settled[k] updates in the same cycle live k is written. A target write also updates Settled[k] on the following edge from the comparison against the current live value.
- Host writes:
  - Take effect at the clock edge.
  - A write to channel k's target or step in the same cycle CALC processes k is stored, but CALC uses the pre-write value. The new value applies from the next tick.
  - Writes never stall and never alter Current directly.
- Enable deasserted mid-sequence: the sequence runs to completion, including the Sync pulse. No new sequence starts while Enable=0.
- A tick arriving while not in IDLE cannot occur, given UPDATE_DIV >= 256. A tick is only acted on in IDLE.

Decomposition:
- Shared package holds:
  - NUM_CH=4 and CH_W=16.
  - FSM state encoding (IDLE, CALC, SYNC_HI).
  - WrAddr field positions (bit 2 target/step select).
  - Minimum UPDATE_DIV constant (256) for an elaboration check.
- One sub-module: dac_ramp_step. It is purely combinational: inputs live, target, step; outputs next value and settled flag. It is instantiated once and muxed by the CALC channel index.

Test Plan:
- Reset then idle with UPDATE_DIV=300, SYNC_WIDTH=4, Enable=1 -> Current=0, Settled=F. Sync pulses every 300 cycles, high for exactly 4 cycles starting tick+5.
- Ch0 step=0x0040, target=0x0100 -> ch0 reads 0x0040, 0x0080, 0x00C0, 0x0100 on successive ticks. Settled[0]=0 until the 4th tick, then 1. The 5th tick leaves ch0 at 0x0100.
- Ch1 step=0x0064, target=0xFF00 (-256) -> ch1 reads 0xFF9C, 0xFF38, 0xFF00. The last step is clamped at the target.
- Ch3 step=0, target=0x7FFF -> Current[63:48]=0x7FFF after the first tick at T+4. Then target=0x8000 with step=0xFFFF -> a single jump to 0x8000 with no overflow.
- Enable=0 with a pending target change -> no Sync and Current unchanged across 3 ticks. Re-enable -> updates resume on the next tick. Deassert at T+2 -> that sequence still completes with its Sync pulse.
- Assert nReset at T+3 mid-CALC -> Current=0, Sync=0, Settled=F immediately. No Sync pulse until the first tick after release.

Source files
------------

// File: rtl/dac_setpoint_ramp_pkg.sv
// Shared constants and types for the DAC setpoint ramp stage.
// Channel geometry, FSM encoding and host address fields.
package dac_setpoint_ramp_pkg;

   localparam int NUM_CH         = 4;
   localparam int CH_W           = 16;
   localparam int CH_IDX_W       = 2;
   localparam int WA_SEL_BIT     = 2;
   localparam int MIN_UPDATE_DIV = 256;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC    = 2'd1,
      ST_SYNC_HI = 2'd2
   } ramp_state_t;

endpackage

// File: rtl/dac_ramp_step.sv
// One slew step for a single channel: move live toward target
// by at most step; a zero step means jump straight to target.
module dac_ramp_step
   import dac_setpoint_ramp_pkg::*;
(
   input  logic [CH_W-1:0] i_live,
   input  logic [CH_W-1:0] i_target,
   input  logic [CH_W-1:0] i_step,
   output logic [CH_W-1:0] o_next,
   output logic            o_settled
);

   logic [CH_W:0] w_diff;
   logic [CH_W:0] w_mag;
   logic          w_jump;

   // 17-bit signed distance and clamp decision
   always_comb begin
      w_diff    = {i_target[CH_W-1], i_target}
                - {i_live[CH_W-1], i_live};
      w_mag     = w_diff[CH_W] ? (~w_diff + 1'b1) : w_diff;
      w_jump    = (i_step == '0) || (w_mag <= {1'b0, i_step});
      o_next    = i_target;
      if (!w_jump) begin
         o_next = w_diff[CH_W] ? (i_live - i_step)
                               : (i_live + i_step);
      end
      o_settled = (o_next == i_target);
   end

endmodule

// File: rtl/dac_setpoint_ramp.sv
// Tick-driven setpoint ramp feeding the 4-channel DAC8564 driver.
// Steps each channel toward its target, then pulses Sync.
module dac_setpoint_ramp
   import dac_setpoint_ramp_pkg::*;
#(
   parameter int UPDATE_DIV = 1000,
   parameter int SYNC_WIDTH = 4
)
(
   input  logic                   Clk,
   input  logic                   nReset,
   input  logic                   WrEn,
   input  logic [2:0]             WrAddr,
   input  logic [CH_W-1:0]        WrData,
   input  logic                   Enable,
   output logic [NUM_CH*CH_W-1:0] Current,
   output logic                   Sync,
   output logic [NUM_CH-1:0]      Settled
);

   localparam int TICK_W = $clog2(UPDATE_DIV);
   localparam int SCNT_W = (SYNC_WIDTH > 1) ? $clog2(SYNC_WIDTH) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UPDATE_DIV - 1);
   localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SYNC_WIDTH - 1);

   if (UPDATE_DIV < MIN_UPDATE_DIV) begin : g_div_chk
      $error("UPDATE_DIV too small for a full driver frame");
   end
   if (SYNC_WIDTH < 1) begin : g_sync_chk
      $error("SYNC_WIDTH must be at least 1");
   end

   logic [TICK_W-1:0]              r_tick_cnt;
   ramp_state_t                    r_state;
   logic [CH_IDX_W-1:0]            r_ch;
   logic [SCNT_W-1:0]              r_scnt;
   logic                           r_sync;
   logic [NUM_CH-1:0][CH_W-1:0]    r_live;
   logic [NUM_CH-1:0][CH_W-1:0]    r_target;
   logic [NUM_CH-1:0][CH_W-1:0]    r_step;
   logic [NUM_CH-1:0]              r_settled;

   logic                           w_tick;
   ramp_state_t                    w_state_nxt;
   logic [CH_IDX_W-1:0]            w_ch_nxt;
   logic [SCNT_W-1:0]              w_scnt_nxt;
   logic                           w_calc;
   logic [CH_W-1:0]                w_next;
   logic                           w_step_settled;
   logic [NUM_CH-1:0][CH_W-1:0]    w_live_new;
   logic [NUM_CH-1:0][CH_W-1:0]    w_tgt_new;
   logic [NUM_CH-1:0]              w_set_upd;
   logic [NUM_CH-1:0]              w_set_val;

   assign w_tick  = (r_tick_cnt == TICK_LAST);
   assign Current = r_live;
   assign Sync    = r_sync;
   assign Settled = r_settled;

   // Free-running update divider, independent of Enable
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_tick_cnt <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   // Sequencer state register and Sync output flop
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_state <= ST_IDLE;
         r_ch    <= '0;
         r_scnt  <= '0;
         r_sync  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_scnt  <= w_scnt_nxt;
         r_sync  <= (w_state_nxt == ST_SYNC_HI);
      end
   end

   // Sequencer next state: one channel per CALC cycle, then Sync
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_scnt_nxt  = r_scnt;
      w_calc      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_tick && Enable) begin
               w_state_nxt = ST_CALC;
               w_ch_nxt    = '0;
            end
         end
         ST_CALC: begin
            w_calc   = 1'b1;
            w_ch_nxt = r_ch + 1'b1;
            if (r_ch == CH_IDX_W'(NUM_CH - 1)) begin
               w_state_nxt = ST_SYNC_HI;
               w_scnt_nxt  = '0;
            end
         end
         ST_SYNC_HI: begin
            w_scnt_nxt = r_scnt + 1'b1;
            if (r_scnt == SCNT_LAST) begin
               w_state_nxt = ST_IDLE;
               w_scnt_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   dac_ramp_step u_step (
      .i_live    (r_live[r_ch]),
      .i_target  (r_target[r_ch]),
      .i_step    (r_step[r_ch]),
      .o_next    (w_next),
      .o_settled (w_step_settled)
   );

   // Per-channel post-edge live/target and Settled refresh
   always_comb begin
      w_live_new = r_live;
      w_tgt_new  = r_target;
      w_set_upd  = '0;
      w_set_val  = r_settled;
      for (int k = 0; k < NUM_CH; k++) begin
         logic calc_k;
         logic twr_k;
         calc_k = w_calc && (r_ch == CH_IDX_W'(k));
         twr_k  = WrEn && !WrAddr[WA_SEL_BIT]
               && (WrAddr[1:0] == CH_IDX_W'(k));
         if (calc_k) begin
            w_live_new[k] = w_next;
         end
         if (twr_k) begin
            w_tgt_new[k] = WrData;
         end
         w_set_upd[k] = calc_k || twr_k;
         if (calc_k && !twr_k) begin
            w_set_val[k] = w_step_settled;
         end else begin
            w_set_val[k] = (w_live_new[k] == w_tgt_new[k]);
         end
      end
   end

   // Live setpoints and settled flags
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_live    <= '0;
         r_settled <= '1;
      end else begin
         r_live <= w_live_new;
         for (int k = 0; k < NUM_CH; k++) begin
            if (w_set_upd[k]) begin
               r_settled[k] <= w_set_val[k];
            end
         end
      end
   end

   // Host target/step register file; CALC reads pre-write values
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         r_target <= '0;
         r_step   <= '0;
      end else if (WrEn) begin
         if (WrAddr[WA_SEL_BIT]) begin
            r_step[WrAddr[1:0]] <= WrData;
         end else begin
            r_target[WrAddr[1:0]] <= WrData;
         end
      end
   end

endmodule
